// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Boot loader; streams bytes into instruction memory, holds core reset
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              error,
   output logic [15:0]       word_count
);

   localparam logic [2:0] c_idle  = 3'd0;
   localparam logic [2:0] c_hdr0  = 3'd1;
   localparam logic [2:0] c_hdr1  = 3'd2;
   localparam logic [2:0] c_data  = 3'd3;
   localparam logic [2:0] c_write = 3'd4;
   localparam logic [2:0] c_done  = 3'd5;
   localparam logic [2:0] c_err   = 3'd6;

   localparam logic [15:0] c_depth = 16'(DEPTH);

   logic [2:0]  r_state;
   logic [15:0] r_n;
   logic [1:0]  r_idx;
   logic [31:0] r_wdata;
   logic [15:0] r_word_count;

   logic        w_hs;
   logic [15:0] w_n_full;
   logic [15:0] w_count_nxt;

   assign w_hs        = in_valid && in_ready;
   assign w_n_full    = {in_byte, r_n[7:0]};
   assign w_count_nxt = r_word_count + 16'd1;

   // All outputs are straight decodes of flops, so reset reaches them at once
   assign in_ready   = (r_state == c_hdr0) || (r_state == c_hdr1) || (r_state == c_data);
   assign imem_we    = (r_state == c_write);
   assign imem_addr  = r_word_count[ADDR_W-1:0];
   assign imem_wdata = r_wdata;
   assign core_rst   = (r_state != c_done);
   assign done       = (r_state == c_done);
   assign error      = (r_state == c_err);
   assign word_count = r_word_count;

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         r_state      <= c_idle;
         r_n          <= 16'd0;
         r_idx        <= 2'd0;
         r_wdata      <= 32'd0;
         r_word_count <= 16'd0;
      end else begin
         case (r_state)
            c_idle, c_done, c_err: begin
               if (start) begin
                  r_state      <= c_hdr0;
                  r_word_count <= 16'd0;
                  r_idx        <= 2'd0;
               end
            end
            c_hdr0: begin
               if (w_hs) begin
                  r_n[7:0] <= in_byte;
                  r_state  <= c_hdr1;
               end
            end
            c_hdr1: begin
               if (w_hs) begin
                  r_n[15:8] <= in_byte;
                  if (w_n_full == 16'd0)
                     r_state <= c_done;
                  else if (w_n_full > c_depth)
                     r_state <= c_err;
                  else
                     r_state <= c_data;
               end
            end
            c_data: begin
               if (w_hs) begin
                  // Little-endian: byte index selects the lane directly
                  case (r_idx)
                     2'd0:    r_wdata[7:0]   <= in_byte;
                     2'd1:    r_wdata[15:8]  <= in_byte;
                     2'd2:    r_wdata[23:16] <= in_byte;
                     default: r_wdata[31:24] <= in_byte;
                  endcase
                  r_idx <= r_idx + 2'd1;
                  if (r_idx == 2'd3)
                     r_state <= c_write;
               end
            end
            c_write: begin
               r_word_count <= w_count_nxt;
               r_state      <= (w_count_nxt == r_n) ? c_done : c_data;
            end
            default: r_state <= c_idle;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader sitting directly upstream of the multicycle core (`MC`) and its instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, writes them sequentially into instruction memory from word address 0, and holds the core in reset until the load completes. It replaces file preloading of instruction memory for synthesizable boot.

## Interface
- `DEPTH`, 64, instruction memory depth in words.
- `ADDR_W`, 6, instruction memory word-address width; `2**ADDR_W >= DEPTH`.
- `clk` input 1: single clock, rising edge.
- `areset` input 1: asynchronous, active-high reset.
- `start` input 1: pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `in_valid` input 1: byte valid.
- `in_byte` input 8: stream byte.
- `in_ready` output 1: loader accepts a byte this cycle.
- `imem_we` output 1: instruction memory write strobe, one cycle per word.
- `imem_addr` output ADDR_W: word address of the write.
- `imem_wdata` output 32: assembled word.
- `core_rst` output 1: active-high reset to `MC.areset`; low only in DONE.
- `done` output 1: load finished, core released.
- `error` output 1: header word count exceeds DEPTH.
- `word_count` output 16: words written so far.

## Operation
- Reset values: `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst`=1, `done`=0, `error`=0, `word_count`=0; state IDLE.
- Stream format: 2-byte little-endian word count N, then N×4 bytes, each word little-endian (first byte → bits [7:0]).
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
- IDLE: `core_rst`=1; `start` → HDR0, clears `word_count`, byte index, `imem_addr` and `error`.
- HDR0: `in_ready`=1; on handshake latch N[7:0] → HDR1.
- HDR1: `in_ready`=1; on handshake latch N[15:8]; if N=0 → DONE; if N>DEPTH → ERR; else → DATA.
- DATA: `in_ready`=1; each handshake shifts byte into lane indexed by 2-bit byte index; on 4th byte → WRITE.
- WRITE: `in_ready`=0, `imem_we`=1 for exactly one cycle with `imem_addr`=`word_count[ADDR_W-1:0]`; `word_count` increments at end of cycle; if new count == N → DONE, else → DATA.
- DONE: `core_rst`=0, `done`=1; `start` → HDR0 (core re-enters reset the next cycle).
- ERR: `error`=1, `core_rst`=1, no writes; `start` → HDR0.
- Bytes are consumed only when `in_valid && in_ready`; `in_valid` with `in_ready`=0 is ignored, not buffered.
- `start` in HDR0/HDR1/DATA/WRITE is ignored.
- N=DEPTH is legal: final write at address DEPTH-1, no wrap.

## Timing
- Registered outputs; all updates on rising `clk`; `areset` takes effect immediately.
- Byte throughput: 1 byte/cycle in HDR/DATA; one bubble cycle (WRITE) per word, so a word costs ≥5 cycles.
- `imem_we` asserts the cycle after the 4th data byte handshake.
- `done`=1 and `core_rst`=0 the cycle after the last WRITE (or after HDR1 when N=0).
- `core_rst` returns to 1 the cycle after `start` is sampled in DONE.
- `areset` mid-load: abort, all outputs to reset values, partially written memory left as is.

## Test plan
- Reset: assert `areset` asynchronously mid-cycle → `core_rst`=1, `in_ready`=0, `done`=0, all other outputs 0 immediately.
- Normal load: `start`, stream 02 00, 13 00 50 00, 93 00 A0 00 → writes 0x00500013 @0 then 0x00A00093 @1, one `imem_we` pulse each; `done`=1, `core_rst`=0, `word_count`=2.
- Throttled source: same stream with `in_valid` toggled randomly → identical writes; no byte lost or duplicated; `in_ready`=0 in WRITE cycles.
- Boundaries: N=0 → DONE two handshakes after start, no writes; N=64 → last write at address 63, `done`=1; N=65 → `error`=1, `core_rst`=1, no writes.
- Abort/restart: `areset` after 5 data bytes → IDLE, `word_count`=0; then full reload of 1 word succeeds; `start` issued in DATA is ignored.
- Reload from DONE: `start` → `core_rst`=1 next cycle, `done`=0, new program overwrites from address 0.
